// File: rtl/readout_sequencer.sv
// Readout sequencer for the 2-row pixel array: row enables, ADC strobe and sample handshake.
//   state   | meaning
//   IDLE    | waiting for Start, all outputs inactive
//   SETTLE  | current row enabled, waiting for the pixels to settle
//   CONV_HI | ADC convert strobe high
//   CONV_LO | ADC converting; sample valid on the last cycle
//   ROW_GAP | both rows released before switching to row 2
//   DONE    | one-cycle completion pulse
module readout_sequencer #(
  parameter int NUM_COLS        = 2,
  parameter int SETTLE_CYCLES   = 2,
  parameter int ADC_HIGH_CYCLES = 1,
  parameter int CONV_CYCLES     = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Abort,
  output logic       NRE_1,
  output logic       NRE_2,
  output logic       ADC,
  output logic       Sample_strobe,
  output logic       Row_idx,
  output logic [7:0] Col_idx,
  output logic       Busy,
  output logic       Done
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CONV_HI,
    CONV_LO,
    ROW_GAP,
    DONE
  } state_t;

  // Down-counters are loaded with duration-1 and leave the state at zero.
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] HIGH_LOAD   = 8'(ADC_HIGH_CYCLES - 1);
  localparam logic [7:0] CONV_LOAD   = 8'(CONV_CYCLES - 1);
  localparam logic [7:0] LAST_COL    = 8'(NUM_COLS - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [7:0] col, col_nxt;
  logic       row, row_nxt;

  logic       nre_1_nxt, nre_2_nxt, adc_nxt, strobe_nxt;
  logic       row_idx_nxt, busy_nxt, done_nxt, row_on;
  logic [7:0] col_idx_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    col_nxt   = col;
    row_nxt   = row;

    case (state)
      IDLE: begin
        if (Start && !Abort) begin
          state_nxt = SETTLE;
          cnt_nxt   = SETTLE_LOAD;
          row_nxt   = 1'b0;
          col_nxt   = 8'd0;
        end
      end
      SETTLE: begin
        if (cnt == 8'd0) begin
          state_nxt = CONV_HI;
          cnt_nxt   = HIGH_LOAD;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      CONV_HI: begin
        if (cnt == 8'd0) begin
          state_nxt = CONV_LO;
          cnt_nxt   = CONV_LOAD;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      CONV_LO: begin
        if (cnt == 8'd0) begin
          if (col < LAST_COL) begin
            col_nxt   = col + 8'd1;
            state_nxt = CONV_HI;
            cnt_nxt   = HIGH_LOAD;
          end else if (!row) begin
            state_nxt = ROW_GAP;
          end else begin
            state_nxt = DONE;
          end
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      ROW_GAP: begin
        state_nxt = SETTLE;
        cnt_nxt   = SETTLE_LOAD;
        row_nxt   = 1'b1;
        col_nxt   = 8'd0;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (Abort && state != IDLE) begin
      state_nxt = IDLE;
      cnt_nxt   = 8'd0;
      col_nxt   = 8'd0;
      row_nxt   = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they change together with it.
  always_comb begin
    row_on      = (state_nxt == SETTLE) || (state_nxt == CONV_HI) || (state_nxt == CONV_LO);
    nre_1_nxt   = !(row_on && !row_nxt);
    nre_2_nxt   = !(row_on && row_nxt);
    adc_nxt     = (state_nxt == CONV_HI);
    strobe_nxt  = (state_nxt == CONV_LO) && (cnt_nxt == 8'd0);
    busy_nxt    = (state_nxt != IDLE);
    done_nxt    = (state_nxt == DONE);
    row_idx_nxt = Row_idx;
    col_idx_nxt = Col_idx;
    if (state_nxt == IDLE) begin
      row_idx_nxt = 1'b0;
      col_idx_nxt = 8'd0;
    end else if (strobe_nxt) begin
      row_idx_nxt = row_nxt;
      col_idx_nxt = col_nxt;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      col           <= 8'd0;
      row           <= 1'b0;
      NRE_1         <= 1'b1;
      NRE_2         <= 1'b1;
      ADC           <= 1'b0;
      Sample_strobe <= 1'b0;
      Row_idx       <= 1'b0;
      Col_idx       <= 8'd0;
      Busy          <= 1'b0;
      Done          <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      col           <= col_nxt;
      row           <= row_nxt;
      NRE_1         <= nre_1_nxt;
      NRE_2         <= nre_2_nxt;
      ADC           <= adc_nxt;
      Sample_strobe <= strobe_nxt;
      Row_idx       <= row_idx_nxt;
      Col_idx       <= col_idx_nxt;
      Busy          <= busy_nxt;
      Done          <= done_nxt;
    end
  end

  a_param_range: assert property (@(posedge Clk)
      (NUM_COLS >= 1) && (NUM_COLS <= 255) &&
      (SETTLE_CYCLES >= 1) && (SETTLE_CYCLES <= 255) &&
      (ADC_HIGH_CYCLES >= 1) && (ADC_HIGH_CYCLES <= 255) &&
      (CONV_CYCLES >= 1) && (CONV_CYCLES <= 255))
    else $error("readout_sequencer: parameter out of range 1..255");

  a_rows_exclusive: assert property (@(posedge Clk) disable iff (Reset) (NRE_1 || NRE_2))
    else $error("readout_sequencer: both row enables active");

endmodule

// File: tb/tb_readout_sequencer.sv
// Bench for readout_sequencer: default and alternate-parameter instances share stimulus
// and are compared every cycle against a cycle-offset timing model.
module tb_readout_sequencer;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Start = 1'b0;
  logic Abort = 1'b0;

  always #5 Clk = ~Clk;

  logic       d_nre1, d_nre2, d_adc, d_stb, d_row, d_busy, d_done;
  logic [7:0] d_col;
  logic       p_nre1, p_nre2, p_adc, p_stb, p_row, p_busy, p_done;
  logic [7:0] p_col;

  readout_sequencer dut_d (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort),
    .NRE_1(d_nre1), .NRE_2(d_nre2), .ADC(d_adc), .Sample_strobe(d_stb),
    .Row_idx(d_row), .Col_idx(d_col), .Busy(d_busy), .Done(d_done)
  );

  readout_sequencer #(
    .NUM_COLS(3), .SETTLE_CYCLES(1), .ADC_HIGH_CYCLES(2), .CONV_CYCLES(1)
  ) dut_p (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort),
    .NRE_1(p_nre1), .NRE_2(p_nre2), .ADC(p_adc), .Sample_strobe(p_stb),
    .Row_idx(p_row), .Col_idx(p_col), .Busy(p_busy), .Done(p_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase = number of cycles since the sampling Start edge (0 = idle).
  int ph_d = 0;
  int ph_p = 0;

  function automatic int seq_len(input int n, input int s, input int h, input int c);
    return 2 * (s + n * (h + c)) + 2;
  endfunction

  function automatic int advance(input int ph, input int n, input int s, input int h, input int c,
                                 input logic st, input logic ab);
    if (ph != 0) begin
      if (ab || ph >= seq_len(n, s, h, c)) return 0;
      return ph + 1;
    end
    return (st && !ab) ? 1 : 0;
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ph_d = 0;
      ph_p = 0;
    end else begin
      ph_d = advance(ph_d, 2, 2, 1, 3, Start, Abort);
      ph_p = advance(ph_p, 3, 1, 2, 1, Start, Abort);
    end
  end

  task automatic cmp_dut(input string tag, input int ph, input int n, input int s, input int h,
                         input int c, input logic nre1, input logic nre2, input logic adc,
                         input logic stb, input logic row, input logic [7:0] col,
                         input logic busy, input logic done);
    int len, o, q, e_row, e_col;
    logic e_nre1, e_nre2, e_adc, e_stb, e_busy, e_done, in_row;
    len = s + n * (h + c);
    e_nre1 = 1; e_nre2 = 1; e_adc = 0; e_stb = 0; e_busy = 0; e_done = 0;
    e_row = 0; e_col = 0; in_row = 0; o = 0;
    if (ph != 0) begin
      e_busy = 1;
      if (ph <= len) begin
        in_row = 1; e_row = 0; o = ph - 1;
      end else if (ph >= len + 2 && ph <= 2 * len + 1) begin
        in_row = 1; e_row = 1; o = ph - len - 2;
      end else if (ph == 2 * len + 2) begin
        e_done = 1;
      end
    end
    if (in_row) begin
      if (e_row == 0) e_nre1 = 0; else e_nre2 = 0;
      if (o >= s) begin
        q = o - s;
        e_col = q / (h + c);
        e_adc = (q % (h + c)) < h;
        e_stb = (q % (h + c)) == (h + c - 1);
      end
    end
    chk({tag, ".NRE_1"}, nre1, e_nre1);
    chk({tag, ".NRE_2"}, nre2, e_nre2);
    chk({tag, ".ADC"}, adc, e_adc);
    chk({tag, ".Sample_strobe"}, stb, e_stb);
    chk({tag, ".Busy"}, busy, e_busy);
    chk({tag, ".Done"}, done, e_done);
    if (e_stb) begin
      chk({tag, ".Row_idx"}, row, e_row);
      chk({tag, ".Col_idx"}, col, e_col);
    end
    chk({tag, ".nre_overlap"}, !nre1 && !nre2, 0);
    chk({tag, ".adc_without_row"}, adc && nre1 && nre2, 0);
  endtask

  always @(negedge Clk) begin
    cmp_dut("d", ph_d, 2, 2, 1, 3, d_nre1, d_nre2, d_adc, d_stb, d_row, d_col, d_busy, d_done);
    cmp_dut("p", ph_p, 3, 1, 2, 1, p_nre1, p_nre2, p_adc, p_stb, p_row, p_col, p_busy, p_done);
  end

  int d_strobes, p_strobes;

  initial begin
    repeat (3) @(posedge Clk);
    #1 Reset = 0;
    chk("reset.Busy", d_busy, 0);
    chk("reset.NRE_1", d_nre1, 1);
    chk("reset.Col_idx", p_col, 0);
    @(posedge Clk); #1;

    // Cycle k: Start high, sampled at the end of this cycle.
    Start = 1;
    d_strobes = 0;
    p_strobes = 0;
    for (int i = 1; i <= 50; i++) begin
      @(posedge Clk); #1;
      if (i <= 22) begin
        if (d_stb) d_strobes++;
        if (p_stb) p_strobes++;
      end
      case (i)
        1:  begin chk("k1.NRE_1", d_nre1, 0); chk("k1.Busy", d_busy, 1); end
        3:  chk("k3.ADC", d_adc, 1);
        6:  begin chk("k6.strobe", d_stb, 1); chk("k6.row", d_row, 0); chk("k6.col", d_col, 0); end
        7:  chk("k7.ADC", d_adc, 1);
        10: begin
              chk("k10.strobe", d_stb, 1); chk("k10.col", d_col, 1);
              chk("p10.strobe", p_stb, 1); chk("p10.col", p_col, 2); chk("p10.row", p_row, 0);
            end
        11: begin chk("k11.NRE_1", d_nre1, 1); chk("k11.NRE_2", d_nre2, 1); end
        12: chk("k12.NRE_2", d_nre2, 0);
        14: chk("k14.ADC", d_adc, 1);
        17: begin chk("k17.strobe", d_stb, 1); chk("k17.row", d_row, 1); chk("k17.col", d_col, 0); end
        21: begin
              chk("k21.strobe", d_stb, 1); chk("k21.row", d_row, 1); chk("k21.col", d_col, 1);
              chk("p21.col", p_col, 2); chk("p21.row", p_row, 1);
            end
        22: begin chk("k22.Done", d_done, 1); chk("p22.Done", p_done, 1); chk("k22.Busy", d_busy, 1); end
        23: begin
              chk("k23.Busy", d_busy, 0);
              chk("d.strobe_count", d_strobes, 4);
              chk("p.strobe_count", p_strobes, 6);
            end
        24: chk("k24.NRE_1", d_nre1, 0);
        32: begin
              chk("abort.NRE_1", d_nre1, 1); chk("abort.ADC", d_adc, 0);
              chk("abort.Busy", d_busy, 0); chk("abort.Done", d_done, 0);
              chk("abort.Col_idx", d_col, 0);
            end
        35: begin chk("start_abort.Busy", d_busy, 0); chk("start_abort.NRE_1", d_nre1, 1); end
        50: chk("pre_reset.ADC", d_adc, 1);
        default: ;
      endcase
      Start = (i == 5 || i == 22 || i == 23 || i == 34 || i == 36);
      Abort = (i == 31 || i == 34);
      if (i == 50) begin
        #2 Reset = 1;
        #1;
        chk("async_reset.NRE_1", d_nre1, 1);
        chk("async_reset.ADC", d_adc, 0);
        chk("async_reset.Busy", d_busy, 0);
        chk("async_reset.Col_idx", d_col, 0);
        chk("async_reset.p_busy", p_busy, 0);
      end
    end

    @(posedge Clk); #1 Reset = 0;
    @(posedge Clk); #1 Start = 1;
    for (int i = 1; i <= 23; i++) begin
      @(posedge Clk); #1;
      Start = 0;
      if (i == 1)  chk("fresh.NRE_1", d_nre1, 0);
      if (i == 22) chk("fresh.Done", d_done, 1);
      if (i == 23) chk("fresh.Busy", d_busy, 0);
    end

    for (int i = 0; i < 2000; i++) begin
      @(posedge Clk); #1;
      Reset = ($urandom_range(0, 999) < 3);
      Start = ($urandom_range(0, 7) == 0);
      Abort = ($urandom_range(0, 39) == 0);
    end
    Reset = 0; Start = 0; Abort = 0;
    repeat (3) @(posedge Clk);
    @(negedge Clk); #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
